// File: rtl/spec_mmu.sv
// Banked memory mapper: splits the 64 KB CPU space into windows,
// each mapped to a physical bank, with boot overlay, write protect and lock.
module spec_mmu #(
  parameter int WIN_BITS  = 2,
  parameter int BANK_W    = 5,
  parameter int MEM_WORDS = 393216,
  parameter int BOOT_BANK = 1,
  parameter int LEGACY    = 0,
  localparam int PHYS_W   = BANK_W + 16 - WIN_BITS
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic [15:0]       cpu_a,
  input  logic [7:0]        cpu_do,
  input  logic              cpu_wr_n,
  input  logic              cpu_rd,
  input  logic              sel,
  input  logic              load_hold,
  output logic [PHYS_W-1:0] phys_addr,
  output logic              phys_valid,
  output logic              mem_we,
  output logic              boot,
  output logic [7:0]        dout
);

  localparam int NW    = 1 << WIN_BITS;
  localparam int OFF_W = 16 - WIN_BITS;
  localparam logic [31:0] MEM_LIM = 32'(MEM_WORDS);
  localparam logic [BANK_W-1:0] BOOT_B = BANK_W'(BOOT_BANK);

  localparam logic ST_BOOT = 1'b1;
  localparam logic ST_RUN  = 1'b0;

  logic [BANK_W-1:0]   bank [NW];
  logic [NW-1:0]       wp;
  logic                lock;
  logic                state;
  logic                old_wr;
  logic                wr_arm;

  logic [WIN_BITS-1:0] win;
  logic [WIN_BITS-1:0] ridx;
  logic [OFF_W-1:0]    off;
  logic [BANK_W-1:0]   eff_bank;
  logic [BANK_W+2:0]   rb;
  logic                wr_ev;
  logic                io_wr;
  logic                boot_exit;
  logic                unused_ok;

  assign win  = cpu_a[15 -: WIN_BITS];
  assign ridx = cpu_a[WIN_BITS+1:2];
  assign off  = cpu_a[OFF_W-1:0];

  // wr_arm blocks a spurious event when cpu_wr_n is held low across reset
  assign wr_ev = old_wr & wr_arm & ~cpu_wr_n;
  assign io_wr = wr_ev & sel;

  assign boot_exit = (io_wr && cpu_a[1:0] == 2'b10)
                   || (LEGACY != 0 && cpu_rd && cpu_a[15]);

  assign boot = (state == ST_BOOT);
  assign rb   = {lock, 2'b00, bank[ridx]};

  assign unused_ok = ^cpu_do;

  // Effective bank selection: tape load beats boot overlay beats registers
  always_comb begin
    eff_bank = bank[win];
    if (load_hold)
      eff_bank = '0;
    else if (boot)
      eff_bank = BOOT_B;
  end

  // Translation and memory write qualification
  always_comb begin
    phys_addr  = {eff_bank, off};
    phys_valid = 32'(phys_addr) < MEM_LIM;
    mem_we     = ~cpu_wr_n & phys_valid & ~wp[win] & ~sel;
  end

  // Strobe edge detect and write-event arming
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      old_wr <= 1'b1;
      wr_arm <= cpu_wr_n;
    end else begin
      old_wr <= cpu_wr_n;
      if (cpu_wr_n)
        wr_arm <= 1'b1;
    end
  end

  // Mapper registers: banks, write protect, lock
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      for (int i = 0; i < NW; i++)
        bank[i] <= '0;
      wp   <= '0;
      lock <= 1'b0;
    end else if (io_wr) begin
      unique case (cpu_a[1:0])
        2'b00: begin
          if (!lock) begin
            if (LEGACY != 0) begin
              for (int i = 0; i < NW; i++)
                bank[i] <= cpu_do[BANK_W-1:0];
            end else begin
              bank[ridx] <= cpu_do[BANK_W-1:0];
            end
          end
        end
        2'b01: begin
          if (!lock)
            wp <= cpu_do[NW-1:0];
        end
        2'b11: begin
          if (cpu_do[7])
            lock <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Boot overlay state: leaves BOOT once, returns only via reset
  always_ff @(posedge clk_sys) begin
    if (RESET)
      state <= ST_BOOT;
    else if (state == ST_BOOT && boot_exit)
      state <= ST_RUN;
  end

  // Register readback latch
  always_ff @(posedge clk_sys) begin
    if (RESET)
      dout <= 8'hFF;
    else if (cpu_rd && sel)
      dout <= 8'(rb);
  end

endmodule

// File: tb/tb_spec_mmu.sv
// Directed bench for spec_mmu: default instance plus a LEGACY=1 instance
// driven from the same stimulus.
module tb_spec_mmu;

  logic        clk_sys = 1'b0;
  logic        RESET = 1'b0;
  logic [15:0] cpu_a = '0;
  logic [7:0]  cpu_do = '0;
  logic        cpu_wr_n = 1'b1;
  logic        cpu_rd = 1'b0;
  logic        sel = 1'b0;
  logic        load_hold = 1'b0;

  logic [18:0] phys_addr;
  logic        phys_valid;
  logic        mem_we;
  logic        boot;
  logic [7:0]  dout;

  logic [18:0] l_phys;
  logic        l_valid;
  logic        l_we;
  logic        l_boot;
  logic [7:0]  l_dout;

  int n_tests = 0;
  int n_fail  = 0;

  spec_mmu u_dut (
    .clk_sys(clk_sys), .RESET(RESET), .cpu_a(cpu_a),
    .cpu_do(cpu_do), .cpu_wr_n(cpu_wr_n), .cpu_rd(cpu_rd),
    .sel(sel), .load_hold(load_hold),
    .phys_addr(phys_addr), .phys_valid(phys_valid),
    .mem_we(mem_we), .boot(boot), .dout(dout)
  );

  spec_mmu #(.LEGACY(1)) u_leg (
    .clk_sys(clk_sys), .RESET(RESET), .cpu_a(cpu_a),
    .cpu_do(cpu_do), .cpu_wr_n(cpu_wr_n), .cpu_rd(cpu_rd),
    .sel(sel), .load_hold(load_hold),
    .phys_addr(l_phys), .phys_valid(l_valid),
    .mem_we(l_we), .boot(l_boot), .dout(l_dout)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic wr_port(input logic [15:0] a, input logic [7:0] d);
    cpu_a = a;
    cpu_do = d;
    sel = 1'b1;
    cpu_wr_n = 1'b0;
    tick();
    cpu_wr_n = 1'b1;
    sel = 1'b0;
    tick();
  endtask

  task automatic rd_port(input logic [15:0] a);
    cpu_a = a;
    sel = 1'b1;
    cpu_rd = 1'b1;
    tick();
    sel = 1'b0;
    cpu_rd = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    do_reset();

    // reset state and boot overlay
    cpu_a = 16'h0123;
    cpu_rd = 1'b1;
    #2;
    check("rst_phys", 32'(phys_addr), 32'h04123);
    check("rst_boot", 32'(boot), 32'h1);
    check("rst_dout", 32'(dout), 32'hFF);
    check("rst_valid", 32'(phys_valid), 32'h1);
    cpu_rd = 1'b0;
    tick();

    // bank write during boot, then boot exit
    wr_port(16'h0008, 8'h03);
    cpu_a = 16'h8010;
    cpu_rd = 1'b1;
    tick();
    check("boot_hold", 32'(boot), 32'h1);
    check("boot_phys", 32'(phys_addr), 32'h04010);
    cpu_rd = 1'b0;
    wr_port(16'h0002, 8'h00);
    cpu_a = 16'h8010;
    #2;
    check("run_boot", 32'(boot), 32'h0);
    check("run_phys", 32'(phys_addr), 32'h0C010);
    load_hold = 1'b1;
    #2;
    check("load_hold", 32'(phys_addr), 32'h00010);
    load_hold = 1'b0;
    rd_port(16'h0008);
    check("rb_win2", 32'(dout), 32'h03);

    // top bank beyond physical memory
    wr_port(16'h000C, 8'h1F);
    cpu_a = 16'hFFFF;
    cpu_wr_n = 1'b0;
    #2;
    check("hi_phys", 32'(phys_addr), 32'h7FFFF);
    check("hi_valid", 32'(phys_valid), 32'h0);
    check("hi_we", 32'(mem_we), 32'h0);
    cpu_wr_n = 1'b1;
    tick();

    // write protect
    wr_port(16'h0001, 8'h01);
    cpu_a = 16'h0100;
    cpu_wr_n = 1'b0;
    #2;
    check("wp_w0_we", 32'(mem_we), 32'h0);
    cpu_a = 16'h4100;
    #2;
    check("wp_w1_we", 32'(mem_we), 32'h1);
    check("wp_w1_phys", 32'(phys_addr), 32'h00100);
    sel = 1'b1;
    #2;
    check("io_no_we", 32'(mem_we), 32'h0);
    sel = 1'b0;
    cpu_wr_n = 1'b1;
    tick();

    // lock
    wr_port(16'h0003, 8'h80);
    wr_port(16'h0008, 8'h07);
    wr_port(16'h0001, 8'h00);
    rd_port(16'h0008);
    check("lock_rb", 32'(dout), 32'h83);
    cpu_a = 16'h0100;
    cpu_wr_n = 1'b0;
    #2;
    check("lock_wp", 32'(mem_we), 32'h0);
    cpu_wr_n = 1'b1;
    tick();
    do_reset();
    check("rst_dout2", 32'(dout), 32'hFF);
    rd_port(16'h0008);
    check("unlock_rb", 32'(dout), 32'h00);
    wr_port(16'h0008, 8'h05);
    rd_port(16'h0008);
    check("unlock_wr", 32'(dout), 32'h05);

    // reset with write strobe held low across release
    cpu_a = 16'h0000;
    cpu_do = 8'h0A;
    sel = 1'b1;
    cpu_wr_n = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    repeat (3) tick();
    cpu_wr_n = 1'b1;
    sel = 1'b0;
    tick();
    rd_port(16'h0000);
    check("rst_midwr", 32'(dout), 32'h00);

    // legacy: read-driven boot exit
    do_reset();
    check("l_rst_boot", 32'(l_boot), 32'h1);
    cpu_a = 16'h8000;
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    #1;
    check("l_rd_exit", 32'(l_boot), 32'h0);
    check("l_phys0", 32'(l_phys), 32'h00000);
    check("d_no_exit", 32'(boot), 32'h1);

    // legacy: held strobe gives one update across all windows
    cpu_a = 16'h0000;
    cpu_do = 8'h02;
    sel = 1'b1;
    cpu_wr_n = 1'b0;
    tick();
    cpu_do = 8'h05;
    repeat (4) tick();
    cpu_wr_n = 1'b1;
    sel = 1'b0;
    tick();
    rd_port(16'h000C);
    check("l_one_upd", 32'(l_dout), 32'h02);

    // legacy: boot exit and bank write in the same cycle
    do_reset();
    cpu_a = 16'h8000;
    cpu_do = 8'h04;
    sel = 1'b1;
    cpu_rd = 1'b1;
    cpu_wr_n = 1'b0;
    tick();
    cpu_wr_n = 1'b1;
    sel = 1'b0;
    cpu_rd = 1'b0;
    tick();
    cpu_a = 16'h4000;
    #2;
    check("l_both_boot", 32'(l_boot), 32'h0);
    check("l_both_phys", 32'(l_phys), 32'h10000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spec_mmu.md
SPEC_MMU -- requirements
Module: spec_mmu

Interface
REQ-001 Parameter WIN_BITS, default 2; log2 of the number of equal CPU windows the 64 KB space is split into (4 windows of 16 KB).
REQ-002 Parameter BANK_W, default 5; width of each window's bank register (32 banks).
REQ-003 Parameter MEM_WORDS, default 393216; number of physical bytes that actually exist.
REQ-004 Parameter BOOT_BANK, default 1; bank forced into every window while boot overlay is active.
REQ-005 Parameter LEGACY, default 0; 1 = single shared page register (old behaviour), 0 = one register per window.
REQ-006 Derived PHYS_W = BANK_W + 16 - WIN_BITS.
REQ-007 clk_sys  in  1  system clock; all state on rising edge.
REQ-008 RESET  in  1  synchronous, active-high reset.
REQ-009 cpu_a  in  16  CPU address bus.
REQ-010 cpu_do  in  8  CPU write data.
REQ-011 cpu_wr_n  in  1  CPU write strobe, active low.
REQ-012 cpu_rd  in  1  CPU read strobe (DBIN), active high.
REQ-013 sel  in  1  mapper I/O port decode from the system decoder.
REQ-014 load_hold  in  1  tape-load override; forces bank 0 in all windows while high.
REQ-015 phys_addr  out  PHYS_W  translated physical address.
REQ-016 phys_valid  out  1  phys_addr < MEM_WORDS.
REQ-017 mem_we  out  1  cpu_wr_n==0 and phys_valid and not write-protected.
REQ-018 boot  out  1  boot overlay active.
REQ-019 dout  out  8  register readback, {lock, 2'b0, bank} zero-extended or truncated to 8 bits.

Function
REQ-020 Write event = cpu_wr_n 1 in previous cycle and 0 in current cycle (edge detect on registered old_wr); exactly one event per CPU write cycle.
REQ-021 On write event with sel=1, cpu_a[1:0]: 00 -> write bank[cpu_a[WIN_BITS+1:2]] = cpu_do[BANK_W-1:0]; 01 -> wp mask = cpu_do[(2^WIN_BITS)-1:0]; 10 -> boot cleared; 11 -> lock set when cpu_do[7]=1.
REQ-022 LEGACY=1: any sub-address 00 write updates all windows' bank registers simultaneously.
REQ-023 lock=1: further bank and wp writes ignored; only RESET clears lock.
REQ-024 Register updates take effect on the edge of the write-event cycle; phys_addr reflects them the following cycle.
REQ-025 Window index w = cpu_a[15:16-WIN_BITS]; phys_addr = {eff_bank(w), cpu_a[15-WIN_BITS:0]}, combinational from cpu_a and registers.
REQ-026 eff_bank priority: load_hold -> 0; boot -> BOOT_BANK; else bank[w].
REQ-027 Boot state machine: BOOT (after reset) -> RUN on a 0x02 write event, or on the first cycle with cpu_rd=1 and cpu_a[15]=1 when LEGACY=1; RUN -> BOOT only via RESET.
REQ-028 Boot exit caused by a read in the same cycle as a bank write: both take effect; bank write is not lost.
REQ-029 mem_we = 0 when wp bit of w is set, phys_valid=0, or sel=1 (I/O cycles never reach memory).
REQ-030 phys_valid comparison is full PHYS_W unsigned; addresses wrapping past MEM_WORDS give phys_valid=0, no alias.
REQ-031 dout registered: on cycle with cpu_rd=1 and sel=1, dout = {lock, 2'b00, bank[cpu_a[WIN_BITS+1:2]]} truncated to 8 bits; otherwise dout holds.
REQ-032 Simultaneous RESET and write event: RESET wins.

Reset
REQ-033 On RESET: all bank registers = 0, wp = 0, lock = 0, boot = 1, old_wr = 1, dout = 8'hFF.
REQ-034 Outputs in reset cycle derived from reset values: phys_addr = {BOOT_BANK, cpu_a low bits}, boot = 1.
REQ-035 RESET mid-write (cpu_wr_n held low across release) produces no write event until cpu_wr_n returns high then low.

Verification
REQ-036 Reset, read 0x0123 -> phys_addr = 0x04123 (BOOT_BANK=1), boot=1, dout=FF.
REQ-037 Write 0x03 to port sub 00 window 2, then 0x02 sub-write to exit boot; read 0x8010 -> phys_addr = 0x0C010.
REQ-038 Bank 0x1F in window 3, access 0xFFFF -> phys_addr 0x7FFFF, phys_valid=0, mem_we=0 on write.
REQ-039 Set wp=0b0001, write to 0x0100 -> mem_we=0; write to 0x4100 -> mem_we=1.
REQ-040 Set lock (0x80 to sub 11), then bank write -> bank unchanged, readback bit7=1; RESET -> lock=0.
REQ-041 LEGACY=1: read from 0x8000 while boot -> boot=0 next cycle; cpu_wr_n held low 5 cycles -> exactly one register update.
